// File: rtl/rename_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile_if
// Description : Rename, commit, flush and read-port bundle for rename_regfile.
//               The master drives requests and addresses. The slave (the
//               register file) returns the read data, busy/tag status and
//               the busy count.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_regfile_if #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic                     ren_valid;
  logic [AW-1:0]            ren_rd;
  logic [TAG_W-1:0]         ren_tag;
  logic                     cmt_valid;
  logic [AW-1:0]            cmt_rd;
  logic [TAG_W-1:0]         cmt_tag;
  logic [DATA_W-1:0]        cmt_data;
  logic                     flush;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD*TAG_W-1:0]  rd_tag;
  logic [CW-1:0]            busy_count;

  modport master (
    output ren_valid, ren_rd, ren_tag,
    output cmt_valid, cmt_rd, cmt_tag, cmt_data,
    output flush, rd_addr,
    input  rd_data, rd_busy, rd_tag, busy_count
  );

  modport slave (
    input  ren_valid, ren_rd, ren_tag,
    input  cmt_valid, cmt_rd, cmt_tag, cmt_data,
    input  flush, rd_addr,
    output rd_data, rd_busy, rd_tag, busy_count
  );
endinterface
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile
// Description : Architectural register file with per-register busy/ROB-tag
//               scoreboard for register renaming. x0 is hardwired zero.
//               Reads are combinational. A rename marks the destination
//               busy. A commit writes the data, and it clears busy only when
//               the stored tag matches. A flush clears every busy bit.
//               Optional macro RENAME_BYPASS_EN makes each read port forward
//               a same-cycle commit to the register being read.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rename_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [CW-1:0]       count_q;

  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d;
  logic [CW-1:0]       count_d;

  logic ren_ok;
  logic cmt_ok;
  logic cmt_release;

  // Requests aimed at x0 are ignored. A flush drops any same-cycle rename.
  assign ren_ok      = bus.ren_valid && (bus.ren_rd != '0) && !bus.flush;
  assign cmt_ok      = bus.cmt_valid && (bus.cmt_rd != '0);
  assign cmt_release = cmt_ok && busy_q[bus.cmt_rd] &&
                       (tag_q[bus.cmt_rd] == bus.cmt_tag);

  // Next busy/tag state: flush, then commit release, then rename (rename wins).
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (cmt_release) begin
        busy_d[bus.cmt_rd] = 1'b0;
      end
      if (ren_ok) begin
        busy_d[bus.ren_rd] = 1'b1;
        tag_d[bus.ren_rd]  = bus.ren_tag;
      end
    end
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  // Population count of the next busy vector. It is registered alongside busy.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + CW'(busy_d[i]);
    end
  end

  // State registers. A commit writes its data whether or not the tag matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= tag_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
      if (cmt_ok) begin
        data_q[bus.cmt_rd] <= bus.cmt_data;
      end
    end
  end

  assign bus.busy_count = count_q;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data_k;
      logic              busy_k;
      logic [TAG_W-1:0]  tag_k;

      assign addr = bus.rd_addr[k*AW +: AW];

      // Combinational read of the current state, with optional commit forwarding.
      always_comb begin
        data_k = data_q[addr];
        busy_k = busy_q[addr];
        tag_k  = tag_q[addr];
`ifdef RENAME_BYPASS_EN
        if (!rst && bus.cmt_valid && (addr != '0) && (addr == bus.cmt_rd)) begin
          data_k = bus.cmt_data;
          if (tag_q[addr] == bus.cmt_tag) begin
            busy_k = 1'b0;
          end
        end
`endif
        if (addr == '0) begin
          data_k = '0;
          busy_k = 1'b0;
          tag_k  = '0;
        end
      end

      assign bus.rd_data[k*DATA_W +: DATA_W] = data_k;
      assign bus.rd_busy[k]                  = busy_k;
      assign bus.rd_tag[k*TAG_W +: TAG_W]    = tag_k;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NUM_REGS, 32: architectural register count; register 0 is hardwired zero.
REQ-003 Parameter DATA_W, 32: register data width.
REQ-004 Parameter TAG_W, 4: ROB tag width.
REQ-005 Parameter NUM_RD, 2: number of read ports.
REQ-006 Derived AW = $clog2(NUM_REGS); derived CW = $clog2(NUM_REGS+1).
REQ-007 Port clk  in  1  sole clock, rising edge.
REQ-008 Port rst  in  1  asynchronous active-high reset.
REQ-009 Port ren_valid  in  1  rename request: mark ren_rd busy.
REQ-010 Port ren_rd  in  AW  rename destination register.
REQ-011 Port ren_tag  in  TAG_W  ROB tag of the renaming instruction.
REQ-012 Port cmt_valid  in  1  commit request from the ROB head.
REQ-013 Port cmt_rd  in  AW  commit destination register.
REQ-014 Port cmt_tag  in  TAG_W  ROB tag of the committing entry.
REQ-015 Port cmt_data  in  DATA_W  committed result.
REQ-016 Port flush  in  1  mispredict flush: clear all busy state.
REQ-017 Port rd_addr  in  NUM_RD*AW  packed read addresses; port k uses slice k.
REQ-018 Port rd_data  out  NUM_RD*DATA_W  packed read data.
REQ-019 Port rd_busy  out  NUM_RD  register awaiting an in-flight producer.
REQ-020 Port rd_tag  out  NUM_RD*TAG_W  producer tag; valid only when rd_busy is set.
REQ-021 Port busy_count  out  CW  registered count of busy registers.

Function
REQ-022 Per register, state SHALL be {data[DATA_W], busy, tag[TAG_W]}.
REQ-023 Reads SHALL be combinational from current state with zero latency.
REQ-024 Reads of register 0 SHALL return data 0, busy 0, tag 0.
REQ-025 A rename in cycle N SHALL be invisible to reads in cycle N and visible from cycle N+1.
REQ-026 A commit SHALL write cmt_data to cmt_rd at the clock edge, for any nonzero cmt_rd, regardless of tag.
REQ-027 A commit SHALL clear busy on cmt_rd only if busy is set and the stored tag equals cmt_tag; otherwise busy and tag SHALL be unchanged.
REQ-028 When rename and commit target the same nonzero register in one cycle, the data SHALL be written and busy/tag SHALL take the rename values.
REQ-029 Flush SHALL clear every busy bit at the edge and SHALL drop a same-cycle rename.
REQ-030 A commit in the flush cycle SHALL still write its data.
REQ-031 Rename or commit to register 0 SHALL have no effect.
REQ-032 busy_count SHALL equal the number of busy registers after each edge and be 0 the cycle after flush.
REQ-033 busy_count SHALL increment on a 0->1 busy transition, decrement on a 1->0 transition, and be unchanged on tag overwrite of an already-busy register.

Reset
REQ-034 While rst is asserted, independent of clk, all data, busy, tag and busy_count SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL discard pending renames and commits of that cycle.

Configuration
REQ-036 Macro RENAME_BYPASS_EN defined: when a read address equals a nonzero cmt_rd with cmt_valid, that port SHALL return cmt_data, and busy 0 if the tag matches.
REQ-037 Macro RENAME_BYPASS_EN undefined: reads SHALL return registered state only, and commit effects become visible in cycle N+1.

Verification
REQ-038 Reset, then read x5 on both ports -> data 0, busy 0, busy_count 0.
REQ-039 Rename x5 tag 3 in cycle 1; read x5 in cycle 1 -> busy 0; read in cycle 2 -> busy 1, tag 3; busy_count 1.
REQ-040 With x5 busy tag 3, commit x5 tag 2 data 0xAA -> data 0xAA, busy 1 tag 3 retained; then commit tag 3 data 0xBB -> busy 0, data 0xBB, busy_count 0.
REQ-041 Commit x7 tag 4 data 0x1234 while x7 is busy with tag 4, reading x7 in the same cycle -> 0x1234 with busy 0 if RENAME_BYPASS_EN is defined; old data with busy 1 if undefined.
REQ-042 Rename x1..x3, then flush with a same-cycle rename of x4 -> all busy 0, x4 not busy, busy_count 0.
REQ-043 Rename x0 tag 1 and commit x0 data 0xFFFFFFFF -> x0 reads 0, not busy, busy_count unchanged.
